// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the four-phase CDC handshake source.
package cdc_hs_pkg;

    localparam int unsigned XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous active-low reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: shift the asynchronous input through two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser stages, cleared while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cdc_hs_src.sv
// Source side of a four-phase req/ack handshake carrying a WIDTH-bit payload
// into another clock domain, with a sticky stall timeout and transfer count.
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  ready_o,
    output logic                  req_o,
    output logic [WIDTH-1:0]      data_o,
    input  logic                  ack_i,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

    localparam int unsigned    TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    hs_state_t              state_q, state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [XFER_CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   ack_s;
    logic                   accept;

    sync2 #(
        .WIDTH(1)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(~rst_i),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    // A stale ack seen while idle blocks new transfers until it clears.
    assign ready_o = (state_q == IDLE) & ~ack_s;
    assign accept  = valid_i & ready_o;

    // Handshake FSM: next state, request, payload capture and completion.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        done_d     = 1'b0;
        xfer_cnt_d = xfer_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    data_d  = data_i;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = REL;
                    req_d   = 1'b0;
                end
            end
            REL: begin
                if (!ack_s) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Stall timer: restarts on every state change, saturates, never aborts.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if ((state_q != IDLE) && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (to_cnt_d == TO_MAX) begin
            timeout_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            xfer_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            xfer_cnt_q <= xfer_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign req_o      = req_q;
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != IDLE);
    assign timeout_o  = timeout_q;
    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Self-checking bench for cdc_hs_src: loopback vectors, back-to-back streaming,
// mid-transfer reset, stale ack, stall timeout and transfer-count wrap.
module tb_cdc_hs_src;

    localparam int unsigned W   = 8;
    localparam int unsigned TOC = 16;
    // Loopback accept-to-accept spacing: 6 busy cycles plus the cycle in
    // which ready_o has returned to 1.
    localparam int LOOP_PERIOD = 7;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [W-1:0] data_i;
    logic        ready_o;
    logic        req_o;
    logic [W-1:0] data_o;
    logic        ack_i;
    logic        done_o;
    logic        busy_o;
    logic        timeout_o;
    logic [15:0] xfer_cnt_o;

    logic loopback;
    logic ack_drv;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb ack_i = loopback ? req_o : ack_drv;

    cdc_hs_src #(
        .WIDTH      (W),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .req_o     (req_o),
        .data_o    (data_o),
        .ack_i     (ack_i),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o),
        .xfer_cnt_o(xfer_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: payload pushed on accept, popped when done_o pulses.
    logic [W-1:0] sb_q[$];

    always @(posedge clk) begin
        if (rst_i) begin
            sb_q.delete();
        end else if (valid_i && ready_o) begin
            sb_q.push_back(data_i);
            check("accept_while_busy", 32'(busy_o), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (done_o) begin
            check("sb_entry_at_done", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                check("sb_data_at_done", 32'(data_o), 32'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        req;
        logic        busy;
        logic        done;
        logic [7:0]  dout;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[8];

    task automatic wait_done(input string name, input int max_cyc, output int seen_cnt);
        seen_cnt = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done_o) begin
                seen_cnt++;
            end
        end
        check(name, 32'(seen_cnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;

        // Single transfer in loopback with ignored valid_i while busy.
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[2] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[4] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd1};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 16'd1};

        rst_i    = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        loopback = 1'b1;
        ack_drv  = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        check("rst_req",     32'(req_o),      32'd0);
        check("rst_busy",    32'(busy_o),     32'd0);
        check("rst_done",    32'(done_o),     32'd0);
        check("rst_timeout", 32'(timeout_o),  32'd0);
        check("rst_cnt",     32'(xfer_cnt_o), 32'd0);
        check("rst_data",    32'(data_o),     32'd0);
        check("rst_ready",   32'(ready_o),    32'd1);

        for (int i = 0; i < 8; i++) begin
            valid_i = vt[i].valid;
            data_i  = vt[i].data;
            tick();
            check($sformatf("vec%0d_ready", i), 32'(ready_o),    32'(vt[i].ready));
            check($sformatf("vec%0d_req", i),   32'(req_o),      32'(vt[i].req));
            check($sformatf("vec%0d_busy", i),  32'(busy_o),     32'(vt[i].busy));
            check($sformatf("vec%0d_done", i),  32'(done_o),     32'(vt[i].done));
            check($sformatf("vec%0d_data", i),  32'(data_o),     32'(vt[i].dout));
            check($sformatf("vec%0d_cnt", i),   32'(xfer_cnt_o), 32'(vt[i].cnt));
        end
        valid_i = 1'b0;

        // Streaming: valid_i held, data_i tracks the edge index.
        for (int k = 0; k < 4 * LOOP_PERIOD; k++) begin
            valid_i = 1'b1;
            data_i  = 8'(k);
            tick();
            if (k % LOOP_PERIOD == 0) begin
                check($sformatf("stream%0d_req", k),  32'(req_o),  32'd1);
                check($sformatf("stream%0d_data", k), 32'(data_o), 32'(8'(k)));
            end else if (k % LOOP_PERIOD == 3) begin
                check($sformatf("stream%0d_rel", k), 32'(req_o), 32'd0);
            end
        end
        valid_i = 1'b0;
        repeat (3) tick();
        check("stream_cnt", 32'(xfer_cnt_o), 32'd5);

        // Reset after edge 1 of a transfer.
        valid_i = 1'b1;
        data_i  = 8'h5A;
        tick();
        valid_i = 1'b0;
        tick();
        check("midrst_pre_req", 32'(req_o), 32'd1);
        rst_i = 1'b1;
        tick();
        check("midrst_req",  32'(req_o),      32'd0);
        check("midrst_busy", 32'(busy_o),     32'd0);
        check("midrst_cnt",  32'(xfer_cnt_o), 32'd0);
        check("midrst_data", 32'(data_o),     32'd0);
        rst_i = 1'b0;
        tick();
        check("midrst_ready", 32'(ready_o), 32'd1);

        // Stale ack held through reset.
        loopback = 1'b0;
        ack_drv  = 1'b1;
        rst_i    = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (2) tick();
        valid_i = 1'b1;
        data_i  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stale%0d_ready", i), 32'(ready_o), 32'd0);
            check($sformatf("stale%0d_busy", i),  32'(busy_o),  32'd0);
        end
        valid_i = 1'b0;
        ack_drv = 1'b0;
        tick();
        check("stale_fall1_ready", 32'(ready_o), 32'd0);
        tick();
        check("stale_fall2_ready", 32'(ready_o), 32'd1);

        // Stall timeout with ack_i held low.
        valid_i = 1'b1;
        data_i  = 8'hC3;
        tick();
        valid_i = 1'b0;
        check("to_req", 32'(req_o), 32'd1);
        for (int e = 1; e <= int'(TOC); e++) begin
            tick();
            if (e == int'(TOC) - 1) begin
                check("to_before", 32'(timeout_o), 32'd0);
            end
        end
        check("to_set",  32'(timeout_o), 32'd1);
        check("to_busy", 32'(busy_o),    32'd1);
        repeat (5) tick();
        check("to_still_req", 32'(req_o),     32'd1);
        check("to_sticky",    32'(timeout_o), 32'd1);
        ack_drv = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (!req_o) seen = 1'b1;
        end
        check("to_req_dropped", 32'(seen), 32'd1);
        ack_drv = 1'b0;
        wait_done("to_done_pulses", 10, n);
        check("to_after_done", 32'(timeout_o),  32'd1);
        check("to_cnt",        32'(xfer_cnt_o), 32'd1);

        // Transfer counter wrap from 0xFFFF.
        loopback = 1'b1;
        force dut.xfer_cnt_q = 16'hFFFF;
        tick();
        release dut.xfer_cnt_q;
        tick();
        check("wrap_preload", 32'(xfer_cnt_o), 32'h0000_FFFF);
        valid_i = 1'b1;
        data_i  = 8'h99;
        tick();
        valid_i = 1'b0;
        wait_done("wrap_done_pulses", 12, n);
        check("wrap_cnt", 32'(xfer_cnt_o), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
